// File: rtl/sht30_i2c_responder.sv
// I2C target that behaves like an SHT30 on the bus: takes 2-byte commands on writes and
// returns a CRC-protected temperature/humidity frame on reads.
module sht30_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h44,
  parameter logic [7:0] CRC_INIT = 8'hFF
) (
  input  logic        clk_50K,
  input  logic        rstn,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [15:0] temp_data,
  input  logic [15:0] hum_data,
  output logic [15:0] cmd,
  output logic        cmd_valid,
  output logic        rd_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD_RX, S_CMD_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        scl_q, sda_q, scl_p, sda_p;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        rw_q, rw_d;
  logic        ack_drv_q, ack_drv_d;
  logic        sda_low_q, sda_low_d;
  logic [7:0]  cmd_hi_q, cmd_hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        rd_done_q, rd_done_d;
  logic [47:0] frame_q, frame_d;

  logic rise, fall, start_c, stop_c;

  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    c = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ w[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign rise    = scl_q & ~scl_p;
  assign fall    = ~scl_q & scl_p;
  assign start_c = scl_q & scl_p & sda_p & ~sda_q;
  assign stop_c  = scl_q & scl_p & ~sda_p & sda_q;

  assign i2c_sda   = sda_low_q ? 1'b0 : 1'bz;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign rd_done   = rd_done_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk_50K) begin
    if (!rstn) begin
      scl_q <= 1'b1;  sda_q <= 1'b1;  scl_p <= 1'b1;  sda_p <= 1'b1;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      byte_idx_q  <= '0;
      rw_q        <= 1'b0;
      ack_drv_q   <= 1'b0;
      sda_low_q   <= 1'b0;
      cmd_hi_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rd_done_q   <= 1'b0;
      frame_q     <= '0;
    end else begin
      scl_q <= i2c_scl;  sda_q <= i2c_sda;  scl_p <= scl_q;  sda_p <= sda_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      byte_idx_q  <= byte_idx_d;
      rw_q        <= rw_d;
      ack_drv_q   <= ack_drv_d;
      sda_low_q   <= sda_low_d;
      cmd_hi_q    <= cmd_hi_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rd_done_q   <= rd_done_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    byte_idx_d  = byte_idx_q;
    rw_d        = rw_q;
    ack_drv_d   = ack_drv_q;
    sda_low_d   = sda_low_q;
    cmd_hi_d    = cmd_hi_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    rd_done_d   = 1'b0;
    frame_d     = frame_q;

    if (stop_c) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
    end else if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      ack_drv_d = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (rise) begin
          shift_d   = {shift_q[6:0], sda_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (shift_q[6:0] == DEV_ADDR) begin
              state_d   = S_ADDR_ACK;
              ack_drv_d = 1'b0;
              rw_d      = sda_q;
              // Frame is frozen here so the whole read returns one consistent sample
              if (sda_q)
                frame_d = {temp_data, crc8(temp_data), hum_data, crc8(hum_data)};
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK, S_CMD_ACK: if (fall) begin
          if (!ack_drv_q) begin
            ack_drv_d = 1'b1;
            sda_low_d = 1'b1;
          end else begin
            ack_drv_d = 1'b0;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            if (state_q == S_ADDR_ACK && rw_q) begin
              state_d    = S_TX;
              sda_low_d  = ~frame_q[47];
              frame_d    = {frame_q[46:0], 1'b0};
              bit_cnt_d  = 4'd1;
              byte_idx_d = '0;
            end else if (state_q == S_ADDR_ACK) begin
              state_d    = S_CMD_RX;
              byte_cnt_d = '0;
            end else begin
              state_d = S_CMD_RX;
              if (byte_cnt_q == 2'd2) begin
                cmd_d       = {cmd_hi_q, shift_q};
                cmd_valid_d = 1'b1;
              end
            end
          end
        end
        S_CMD_RX: if (rise) begin
          shift_d   = {shift_q[6:0], sda_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == 2'd0) cmd_hi_d = {shift_q[6:0], sda_q};
            if (byte_cnt_q < 2'd2) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = S_CMD_ACK;
              ack_drv_d  = 1'b0;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_TX: if (fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_low_d = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_TX_ACK;
          end else begin
            sda_low_d = ~frame_q[47];
            frame_d   = {frame_q[46:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TX_ACK: if (rise) begin
          if (sda_q) begin
            state_d = S_WAIT_STOP;
          end else if (byte_idx_q == 3'd5) begin
            rd_done_d = 1'b1;
            state_d   = S_WAIT_STOP;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            bit_cnt_d  = '0;
            state_d    = S_TX;
          end
        end
        S_WAIT_STOP: sda_low_d = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sht30_i2c_responder.sv
// Directed bench for sht30_i2c_responder: a bit-banged I2C master on a pulled-up SDA line
// exercises writes, reads, wrong address, early NACK, repeated START and mid-read reset.
module tb_sht30_i2c_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        scl;
  logic        m_low;
  logic [15:0] temp, hum;
  wire  [15:0] cmd;
  wire         cmd_valid, rd_done, busy;
  wire         sda_w;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  sht30_i2c_responder dut (
    .clk_50K  (clk),
    .rstn     (rstn),
    .i2c_scl  (scl),
    .i2c_sda  (sda_w),
    .temp_data(temp),
    .hum_data (hum),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .rd_done  (rd_done),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cv_cnt  = 0;
  int rd_cnt  = 0;
  int low_cnt = 0;

  // Pulse widths and any DUT pull-down while the master has released the line
  always @(negedge clk) begin
    if (cmd_valid) cv_cnt++;
    if (rd_done) rd_cnt++;
    if (!m_low && sda_w === 1'b0) low_cnt++;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    cyc(2); m_low = ~b; cyc(2); scl = 1'b1; cyc(4); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    cyc(2); m_low = 1'b0; cyc(2); scl = 1'b1; cyc(2); b = sda_w; cyc(2); scl = 1'b0;
  endtask

  task automatic i2c_start();
    cyc(2); m_low = 1'b0; cyc(2); scl = 1'b1; cyc(4); m_low = 1'b1; cyc(4); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(2); m_low = 1'b1; cyc(2); scl = 1'b1; cyc(4); m_low = 1'b0; cyc(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_n);
    $display("[TB] write 0x%02h ack_n=%0b", d, ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack);
    $display("[TB] read 0x%02h master_ack=%0b", d, ack);
  endtask

  logic [7:0] rb;
  logic       an, bit_v;
  int         cv0, rd0, low0;
  logic [7:0] exp_frame [6];

  initial begin
    rstn = 1'b0; scl = 1'b1; m_low = 1'b0; temp = 16'hBEEF; hum = 16'hBEEF;
    cyc(5);
    check_eq("rst_busy", 16'(busy), 16'h0);
    check_eq("rst_cmd", cmd, 16'h0000);
    check_eq("rst_cmd_valid", 16'(cmd_valid), 16'h0);
    check_eq("rst_rd_done", 16'(rd_done), 16'h0);
    check_eq("rst_sda", 16'(sda_w), 16'h1);
    rstn = 1'b1;
    cyc(5);

    // 1: write command 0x2400
    cv0 = cv_cnt;
    i2c_start();
    write_byte(8'h88, an); check_eq("t1_ack_addr", 16'(an), 16'h0);
    write_byte(8'h24, an); check_eq("t1_ack_b0", 16'(an), 16'h0);
    write_byte(8'h00, an); check_eq("t1_ack_b1", 16'(an), 16'h0);
    i2c_stop();
    cyc(4);
    check_eq("t1_cmd", cmd, 16'h2400);
    check_eq("t1_cmd_valid_cycles", 16'(cv_cnt - cv0), 16'd1);
    check_eq("t1_busy", 16'(busy), 16'h0);
    $display("[TB] test1 write done, cmd=0x%04h", cmd);

    // 2: full read, input changes after the address are ignored
    exp_frame = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92};
    rd0 = rd_cnt;
    i2c_start();
    write_byte(8'h89, an); check_eq("t2_ack_addr", 16'(an), 16'h0);
    temp = 16'h0000; hum = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      read_byte(rb, 1'b1);
      check_eq($sformatf("t2_byte%0d", k), 16'(rb), 16'(exp_frame[k]));
    end
    i2c_stop();
    cyc(4);
    check_eq("t2_rd_done_cycles", 16'(rd_cnt - rd0), 16'd1);
    check_eq("t2_sda_released", 16'(sda_w), 16'h1);
    check_eq("t2_busy", 16'(busy), 16'h0);
    temp = 16'hBEEF; hum = 16'hBEEF;

    // 3: wrong address is ignored
    low0 = low_cnt;
    i2c_start();
    write_byte(8'h8A, an); check_eq("t3_nack_addr", 16'(an), 16'h1);
    write_byte(8'h24, an); check_eq("t3_nack_data", 16'(an), 16'h1);
    check_eq("t3_busy_wait_stop", 16'(busy), 16'h1);
    i2c_stop();
    cyc(4);
    check_eq("t3_no_pulldown", 16'(low_cnt - low0), 16'd0);
    check_eq("t3_busy", 16'(busy), 16'h0);
    check_eq("t3_cmd", cmd, 16'h2400);

    // 4: master NACKs the second byte
    rd0 = rd_cnt;
    i2c_start();
    write_byte(8'h89, an); check_eq("t4_ack_addr", 16'(an), 16'h0);
    read_byte(rb, 1'b1); check_eq("t4_byte0", 16'(rb), 16'h00BE);
    read_byte(rb, 1'b0); check_eq("t4_byte1", 16'(rb), 16'h00EF);
    low0 = low_cnt;
    cyc(6);
    check_eq("t4_released_after_nack", 16'(low_cnt - low0), 16'd0);
    i2c_stop();
    cyc(4);
    check_eq("t4_no_rd_done", 16'(rd_cnt - rd0), 16'd0);
    i2c_start();
    write_byte(8'h89, an);
    read_byte(rb, 1'b0); check_eq("t4_restart_byte0", 16'(rb), 16'h00BE);
    i2c_stop();

    // 5: partial write then repeated START into a read
    temp = 16'h0000; hum = 16'hBEEF;
    exp_frame = '{8'h00, 8'h00, 8'h81, 8'hBE, 8'hEF, 8'h92};
    cv0 = cv_cnt;
    i2c_start();
    write_byte(8'h88, an); check_eq("t5_ack_addr_w", 16'(an), 16'h0);
    write_byte(8'h31, an); check_eq("t5_ack_b0", 16'(an), 16'h0);
    i2c_start();
    write_byte(8'h89, an); check_eq("t5_ack_addr_r", 16'(an), 16'h0);
    for (int k = 0; k < 6; k++) begin
      read_byte(rb, k < 5);
      check_eq($sformatf("t5_byte%0d", k), 16'(rb), 16'(exp_frame[k]));
    end
    i2c_stop();
    cyc(4);
    check_eq("t5_cmd_unchanged", cmd, 16'h2400);
    check_eq("t5_no_cmd_valid", 16'(cv_cnt - cv0), 16'd0);

    // 6: reset while the DUT is pulling SDA low for a 0 data bit
    temp = 16'hBEEF; hum = 16'hBEEF;
    i2c_start();
    write_byte(8'h89, an); check_eq("t6_ack_addr", 16'(an), 16'h0);
    read_bit(bit_v); check_eq("t6_bit7", 16'(bit_v), 16'h1);
    cyc(3);
    check_eq("t6_driving_zero", 16'(sda_w), 16'h0);
    rstn = 1'b0;
    cyc(1);
    check_eq("t6_sda_released", 16'(sda_w), 16'h1);
    check_eq("t6_busy", 16'(busy), 16'h0);
    check_eq("t6_cmd", cmd, 16'h0000);
    check_eq("t6_cmd_valid", 16'(cmd_valid), 16'h0);
    check_eq("t6_rd_done", 16'(rd_done), 16'h0);
    rstn = 1'b1;
    cyc(2);
    i2c_stop();
    i2c_start();
    write_byte(8'h89, an); check_eq("t6_ack_after_rst", 16'(an), 16'h0);
    read_byte(rb, 1'b0); check_eq("t6_byte0_after_rst", 16'(rb), 16'h00BE);
    i2c_stop();
    cyc(4);
    check_eq("t6_busy_end", 16'(busy), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
